fetch_unit: RTL and testbench

//  Program-counter / instruction-fetch stage sitting directly upstream of the 64x16 instruction ROM.

---
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Program-counter / instruction-fetch stage feeding decode from a combinational 64x16 ROM.
// Holds one instruction behind a valid/ready handshake and supports branch redirects and HALT detection.
module fetch_unit #(
   parameter int               ADDR_W   = 6,
   parameter int               DATA_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [6:0]       HALT_OPC = 7'b1111000
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_data,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              halted,
   output logic [15:0]       fetch_count
);

   typedef enum logic {RUN, HALTED} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [DATA_W-1:0]  instr_q, instr_d;
   logic [ADDR_W-1:0]  ipc_q, ipc_d;
   logic               vld_q, vld_d;
   logic [15:0]        cnt_q, cnt_d;
   logic               load;
   logic               is_halt;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign imem_addr   = pc_q;
   assign instr_out   = instr_q;
   assign instr_pc    = ipc_q;
   assign instr_valid = vld_q;
   assign halted      = (state_q == HALTED);
   assign fetch_count = cnt_q;

   assign load    = !vld_q || instr_ready;
   assign is_halt = (imem_data[DATA_W-1:DATA_W-7] == HALT_OPC);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      vld_d   = vld_q;
      cnt_d   = cnt_q;
      if (redirect_valid) begin
         // wrong-path word is dropped; target word arrives on the following clock
         pc_d    = redirect_pc;
         vld_d   = 1'b0;
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (load) begin
                  instr_d = imem_data;
                  ipc_d   = pc_q;
                  vld_d   = 1'b1;
                  cnt_d   = sat_inc(cnt_q);
                  if (is_halt) state_d = HALTED;
                  else         pc_d    = pc_q + 1'b1;
               end
            end
            HALTED: begin
               if (vld_q && instr_ready) vld_d = 1'b0;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         ipc_q   <= '0;
         vld_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a ROM array, a behavioural reference model checked
// on every negedge, and directed scenarios with hand-computed expectations.
module tb_fetch_unit;

   localparam int ADDR_W = 6;
   localparam int DATA_W = 16;
   localparam logic [15:0] HALT_WORD = 16'hF1FF;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [ADDR_W-1:0] imem_addr;
   logic [DATA_W-1:0] imem_data;
   logic [DATA_W-1:0] instr_out;
   logic [ADDR_W-1:0] instr_pc;
   logic              instr_valid;
   logic              instr_ready;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              halted;
   logic [15:0]       fetch_count;

   logic [DATA_W-1:0] rom [0:63];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign imem_data = rom[imem_addr];

   fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
      .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .halted(halted), .fetch_count(fetch_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: what the fetch stage must hold after each clock edge.
   logic [ADDR_W-1:0] m_pc;
   logic [DATA_W-1:0] m_out;
   logic [ADDR_W-1:0] m_ipc;
   logic              m_valid, m_halt, m_init = 1'b0;
   logic [15:0]       m_cnt;

   always @(posedge clk) begin
      logic [DATA_W-1:0] w;
      if (!rst_n) begin
         m_pc = '0; m_out = '0; m_ipc = '0; m_valid = 0; m_halt = 0; m_cnt = '0;
         m_init = 1'b1;
      end else if (m_init) begin
         if (redirect_valid) begin
            m_pc = redirect_pc; m_valid = 0; m_halt = 0;
         end else if (!m_halt) begin
            if (!m_valid || instr_ready) begin
               w = rom[m_pc];
               m_out = w; m_ipc = m_pc; m_valid = 1;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
               if (w[15:9] == 7'b1111000) m_halt = 1;
               else m_pc = m_pc + 6'd1;
            end
         end else if (m_valid && instr_ready) begin
            m_valid = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         check("model_imem_addr", imem_addr, m_pc);
         check("model_valid", instr_valid, m_valid);
         check("model_halted", halted, m_halt);
         check("model_count", fetch_count, m_cnt);
         check("model_instr_out", instr_out, m_out);
         check("model_instr_pc", instr_pc, m_ipc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 16'h1000 + 16'(i);
      rom[7] = HALT_WORD;
      rst_n = 0; instr_ready = 1; redirect_valid = 0; redirect_pc = '0;

      // Reset, with a redirect pending that reset must discard
      redirect_valid = 1; redirect_pc = 6'd40;
      tick(); tick();
      check("rst_valid", instr_valid, 0);
      check("rst_addr", imem_addr, 0);
      check("rst_count", fetch_count, 0);
      check("rst_halted", halted, 0);
      check("rst_instr", instr_out, 0);
      redirect_valid = 0;
      rst_n = 1;

      // T1 straight-line
      for (int k = 0; k < 6; k++) begin
         tick();
         check("t1_valid", instr_valid, 1);
         check("t1_pc", instr_pc, k);
      end
      check("t1_count", fetch_count, 6);

      // Branch to 2 (with decode stalled: redirect ignores instr_ready)
      instr_ready = 0; redirect_valid = 1; redirect_pc = 6'd2;
      tick();
      check("br_valid", instr_valid, 0);
      check("br_addr", imem_addr, 2);
      check("br_count", fetch_count, 6);
      redirect_valid = 0; instr_ready = 1;
      tick();
      check("br_pc", instr_pc, 2);
      check("br_valid2", instr_valid, 1);
      check("br_count2", fetch_count, 7);

      // T2 stall 3 cycles at instr_pc=2
      instr_ready = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t2_pc", instr_pc, 2);
         check("t2_instr", instr_out, 16'h1002);
         check("t2_addr", imem_addr, 3);
         check("t2_count", fetch_count, 7);
      end
      instr_ready = 1;
      tick();
      check("t2_resume", instr_pc, 3);
      check("t2_count2", fetch_count, 8);
      tick(); tick(); tick();
      check("t3_pc6", instr_pc, 6);

      // T4 HALT at 7
      tick();
      check("t4_halted", halted, 1);
      check("t4_instr", instr_out, HALT_WORD);
      check("t4_addr", imem_addr, 7);
      check("t4_count", fetch_count, 12);
      instr_ready = 0;
      tick(); tick();
      check("t4_hold_valid", instr_valid, 1);
      check("t4_hold_pc", instr_pc, 7);
      instr_ready = 1;
      tick();
      check("t4_consumed", instr_valid, 0);
      check("t4_halt_stays", halted, 1);
      tick();
      check("t4_addr2", imem_addr, 7);
      check("t4_count2", fetch_count, 12);

      // T5 redirect while halted
      redirect_valid = 1; redirect_pc = 6'd0;
      tick();
      check("t5_halted", halted, 0);
      check("t5_valid", instr_valid, 0);
      redirect_valid = 0;
      tick();
      check("t5_pc", instr_pc, 0);
      check("t5_count", fetch_count, 13);

      // T6 wrap then reset mid-stall
      redirect_valid = 1; redirect_pc = 6'd62;
      tick();
      redirect_valid = 0;
      tick();
      check("t6_pc62", instr_pc, 62);
      tick();
      check("t6_pc63", instr_pc, 63);
      check("t6_wrap", imem_addr, 0);
      tick();
      check("t6_pc0", instr_pc, 0);
      instr_ready = 0;
      tick();
      rst_n = 0;
      tick();
      check("t6_rst_valid", instr_valid, 0);
      check("t6_rst_addr", imem_addr, 0);
      check("t6_rst_count", fetch_count, 0);
      check("t6_rst_pc", instr_pc, 0);
      rst_n = 1; instr_ready = 1;
      tick();
      check("t6_first", instr_valid, 1);
      check("t6_first_instr", instr_out, 16'h1000);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

endmodule
